// File: rtl/uart_tx_port.sv
// Byte-store driven UART transmitter: small TX FIFO feeding an 8N1 serializer with pollable status.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             WrEnable,
  input  logic [7:0]       WrData,
  input  logic             ClearOverflow,
  output logic             Tx,
  output logic             Full,
  output logic             Empty,
  output logic [CNT_W-1:0] FifoCount,
  output logic             Busy,
  output logic             Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_next;
  state_t           state;
  logic [BW-1:0]    baud;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             baud_end, pop, push;
`ifdef UART_TX_PARITY_EN
  logic             par;
`endif

  assign baud_end = (baud == BAUD_LAST);
  // The serializer pops either from IDLE or at the very end of a stop bit.
  assign pop  = !Empty && ((state == IDLE) || (state == STOP && baud_end));
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign push = WrEnable && (!Full || pop);
  assign Busy = (state != IDLE) || !Empty;

  always_comb begin
    count_next = FifoCount;
    if (push && !pop)      count_next = FifoCount + CNT_W'(1);
    else if (!push && pop) count_next = FifoCount - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= WrData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      FifoCount <= '0;
      Empty     <= 1'b1;
      Full      <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      FifoCount <= count_next;
      Empty     <= (count_next == '0);
      Full      <= (count_next == CNT_FULL);
      // Set beats clear when a drop and a clear land together.
      if (WrEnable && !push)  Overflow <= 1'b1;
      else if (ClearOverflow) Overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      Tx      <= 1'b1;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          Tx   <= 1'b1;
          baud <= '0;
          if (!Empty) begin
            shreg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            par   <= ^mem[rd_ptr];
`endif
            state <= START;
            Tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_cnt <= '0;
            Tx      <= shreg[0];
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              Tx    <= par;
`else
              state <= STOP;
              Tx    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= shreg >> 1;
              Tx      <= shreg[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud  <= '0;
            state <= STOP;
            Tx    <= 1'b1;
          end else begin
            baud <= baud + BW'(1);
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            // Back-to-back frames: go straight to the next start bit.
            if (!Empty) begin
              shreg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
              par   <= ^mem[rd_ptr];
`endif
              state <= START;
              Tx    <= 1'b0;
            end else begin
              state <= IDLE;
              Tx    <= 1'b1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          Tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
